// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder for the CPU MEM stage: latches a load/store,
// stalls the pipeline for LATENCY cycles, then acknowledges with data or an error.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0]   ADDR_LIM = 33'(DEPTH_WORDS) << 2;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          req_err;
  logic          enter_done;
  logic          acc_we, acc_err, mem_we;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_wdata;

  assign req_err = (addr_i[1:0] != 2'b00) || ({1'b0, addr_i} >= ADDR_LIM);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (req_i) begin
        we_d    = we_i;
        idx_d   = addr_i[AW+1:2];
        wdata_d = wdata_i;
        err_d   = req_err;
        cnt_d   = CNT_INIT;
        state_d = (LATENCY == 1) ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With LATENCY=1 the access edge is the acceptance edge, so the live
  // inputs stand in for the not-yet-latched request.
  always_comb begin
    enter_done = (state_d == S_DONE) && (state_q != S_DONE);
    if (state_q == S_IDLE) begin
      acc_we    = we_i;
      acc_idx   = addr_i[AW+1:2];
      acc_wdata = wdata_i;
      acc_err   = req_err;
    end else begin
      acc_we    = we_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      acc_err   = err_q;
    end
    mem_we  = 1'b0;
    rdata_d = rdata_q;
    if (enter_done) begin
      mem_we  = acc_we && !acc_err;
      rdata_d = (acc_we || acc_err) ? 32'h0 : mem_q[acc_idx];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Array has no reset; contents survive it, but a held reset blocks writes.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) mem_q[acc_idx] <= acc_wdata;
  end

  assign stall_o = (state_q == S_BUSY) || ((state_q == S_IDLE) && req_i);
  assign ack_o   = (state_q == S_DONE);
  assign err_o   = (state_q == S_DONE) && err_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one LATENCY=3 and one LATENCY=1 instance,
// expected responses queued at request time and checked on the acknowledge cycle.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        stall [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  typedef struct {
    logic [31:0] rd;
    logic        er;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mdl [2][256];
  int          n_asrt = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_lat3 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .stall_o(stall[0]), .ack_o(ack[0]), .rdata_o(rdata[0]),
    .err_o(err[0])
  );

  data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .stall_o(stall[1]), .ack_o(ack[1]), .rdata_o(rdata[1]),
    .err_o(err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on instance d; leaves req high so callers can chain requests.
  task automatic access(input int d, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input bit scramble);
    int   lat;
    exp_t e;
    lat  = (d == 0) ? 3 : 1;
    e.er = (a[1:0] != 2'b00) || (a >= 32'h400);
    e.rd = (w || e.er) ? 32'h0 : mdl[d][a[9:2]];
    sb.push_back(e);
    if (w && !e.er) mdl[d][a[9:2]] = wd;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
      end else if (scramble && k < lat) begin
        addr[d] = $urandom; wdata[d] = $urandom;
      end
      #1;
      chk($sformatf("stall d%0d a%h k%0d", d, a, k), {31'b0, stall[d]}, (k < lat) ? 32'd1 : 32'd0);
      chk($sformatf("ack d%0d a%h k%0d", d, a, k), {31'b0, ack[d]}, (k == lat) ? 32'd1 : 32'd0);
      if (k == lat) begin
        e = sb.pop_front();
        chk($sformatf("rdata d%0d a%h", d, a), rdata[d], e.rd);
        chk($sformatf("err d%0d a%h", d, a), {31'b0, err[d]}, {31'b0, e.er});
      end
      @(posedge clk);
    end
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    req[d] = 1'b0;
    #1;
    chk($sformatf("idle stall d%0d", d), {31'b0, stall[d]}, 32'd0);
    chk($sformatf("idle ack d%0d", d), {31'b0, ack[d]}, 32'd0);
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst stall d%0d", i), {31'b0, stall[i]}, 32'd0);
      chk($sformatf("rst ack d%0d", i), {31'b0, ack[i]}, 32'd0);
      chk($sformatf("rst err d%0d", i), {31'b0, err[i]}, 32'd0);
      chk($sformatf("rst rdata d%0d", i), rdata[i], 32'd0);
    end
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk);

    // Store then back-to-back load (LATENCY=3), BUSY-cycle input changes ignored.
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    access(0, 1'b0, 32'h10, 32'h0, 1'b1);
    idle(0);

    // LATENCY=1 store/load.
    access(1, 1'b1, 32'h0, 32'h12345678, 1'b0);
    idle(1);
    access(1, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(1);

    // Misaligned store is dropped; old word survives.
    access(0, 1'b1, 32'h13, 32'hFFFFFFFF, 1'b0);
    idle(0);
    access(0, 1'b0, 32'h10, 32'h0, 1'b0);
    idle(0);

    // Range boundary: last word valid, first word past the end faults.
    access(0, 1'b1, 32'h3FC, 32'hCAFEF00D, 1'b0);
    access(0, 1'b0, 32'h3FC, 32'h0, 1'b0);
    access(0, 1'b0, 32'h400, 32'h0, 1'b0);
    access(0, 1'b1, 32'h400, 32'h55555555, 1'b0);
    idle(0);
    access(1, 1'b0, 32'h400, 32'h0, 1'b0);
    idle(1);

    // Continuous req over two loads.
    access(0, 1'b1, 32'h20, 32'd5, 1'b0);
    access(0, 1'b1, 32'h24, 32'd9, 1'b0);
    idle(0);
    access(0, 1'b0, 32'h20, 32'h0, 1'b0);
    access(0, 1'b0, 32'h24, 32'h0, 1'b0);
    idle(0);

    // Reset during the first BUSY cycle drops the pending store.
    access(0, 1'b1, 32'h30, 32'h11, 1'b0);
    idle(0);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'hAA;
    #1;
    chk("abort accept stall", {31'b0, stall[0]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; req[0] = 1'b0;
    #1;
    chk("abort stall", {31'b0, stall[0]}, 32'd0);
    chk("abort ack", {31'b0, ack[0]}, 32'd0);
    chk("abort rdata", rdata[0], 32'd0);
    chk("abort err", {31'b0, err[0]}, 32'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk);
    idle(0);
    access(0, 1'b0, 32'h30, 32'h0, 1'b0);
    idle(0);

    chk("scoreboard drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Multi-cycle data-memory responder serving the pipelined CPU's MEM-stage load/store requests. It latches each request, holds the pipeline with `stall_o` for a fixed access latency, then completes the access in one acknowledge cycle with read data or an error flag. It replaces the single-cycle data memory, so the CPU is the initiator and this block is the responder.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; a power of two, at least 2.
- `LATENCY`, 3: cycles from request acceptance to acknowledge; at least 1.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset; asynchronous, active-high.
- `req_i` in 1: MEM stage holds a load or store; held stable while `stall_o` is high.
- `we_i` in 1: 1 = store, 0 = load.
- `addr_i` in 32: byte address.
- `wdata_i` in 32: store data.
- `stall_o` out 1: freeze PC and all pipeline registers this cycle.
- `ack_o` out 1: access completes this cycle; one-cycle pulse.
- `rdata_o` out 32: load data, valid while `ack_o` is high.
- `err_o` out 1: access faulted; valid while `ack_o` is high.

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- Registers: latched `we`, latched word index, latched `wdata`, latched error bit, a down-counter of width clog2(LATENCY) (at least 1), `rdata_o`, and the word array.
- IDLE with `req_i`=1: accept the request.
  - Latch `we_i`, `addr_i`, `wdata_i`.
  - Latch the error bit = (`addr_i[1:0]`≠0) or (`addr_i` ≥ 4·DEPTH_WORDS).
  - Load the counter with LATENCY−1.
  - Go to DONE if LATENCY=1, else go to BUSY.
- IDLE with `req_i`=0: stay in IDLE.
- BUSY: decrement the counter each cycle. On the edge where the counter equals 1, go to DONE.
- On the edge entering DONE (the access edge):
  - Store with no error: write the word at index `addr[log2(4·DEPTH_WORDS)-1:2]`.
  - Load with no error: register the array word into `rdata_o`.
  - Any error: suppress the write and set `rdata_o`=0.
  - Store: `rdata_o` = 0.
- DONE: `ack_o`=1 and `err_o` = latched error bit. Always go to IDLE next cycle, regardless of `req_i`.
- Outputs:
  - `stall_o` = (state=BUSY) or (state=IDLE and `req_i`=1). This is combinational from `req_i`.
  - `ack_o` = (state=DONE).
  - `err_o` = (state=DONE) and latched error bit.
- `req_i`, `addr_i` and `wdata_i` changing while in BUSY have no effect; the latched request completes.
- `req_i`=1 during DONE is the request being completed and is not re-accepted.
- The array is not initialised by reset. Contents survive reset.

## Timing
- Request first seen in IDLE at cycle t:
  - `stall_o`=1 in cycles t … t+LATENCY−1.
  - `ack_o`=1 in cycle t+LATENCY.
  - CPU advances at the end of cycle t+LATENCY.
- Back-to-back requests:
  - The earliest next acceptance is cycle t+LATENCY+1, one IDLE cycle after DONE.
  - Sustained throughput is one access per LATENCY+1 cycles.
- Read-after-write: a load accepted after a store's DONE cycle returns the stored value.
- Reset values (immediate, asynchronous): state IDLE, counter 0, `ack_o`=0, `err_o`=0, `rdata_o`=0. `stall_o` then follows `req_i`.
- Reset mid-access (BUSY or DONE):
  - The pending store is dropped if reset asserts before the access edge.
  - No `ack_o` is produced for the aborted request.

## Test plan
- Reset, then with LATENCY=3, store 0xDEADBEEF to address 0x10 at cycle 0.
  - Required: `stall_o` high in cycles 0–2, `ack_o` high in cycle 3 with `err_o`=0.
  - Then a load of 0x10 accepted at cycle 4 returns `rdata_o`=0xDEADBEEF with `ack_o` in cycle 7.
- LATENCY=1: load from address 0x0 after a prior store of 0x12345678.
  - Required: `stall_o` high in cycle 0 only, `ack_o` high in cycle 1, `rdata_o`=0x12345678.
- Misaligned store to address 0x13 with data 0xFFFFFFFF.
  - Required: `ack_o` and `err_o` high in cycle LATENCY, `rdata_o`=0.
  - Then a load of 0x10 still returns the old word.
- Out-of-range load at address 4·DEPTH_WORDS (0x400 for DEPTH_WORDS=256).
  - Required: `err_o`=1 with `ack_o`, `rdata_o`=0.
- Hold `req_i`=1 continuously for two loads: load 0x20 (stored value 5), then load 0x24 (stored value 9).
  - Required: acks at cycles LATENCY and 2·LATENCY+1, returning 5 then 9.
  - `stall_o`=0 in each ack cycle.
- Store to address 0x30 (value 0xAA); assert `rst_i` in the first BUSY cycle.
  - Required: `stall_o`, `ack_o`, `rdata_o` drop to 0 immediately and state is IDLE.
  - A later load of 0x30 does not return 0xAA.
